axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
// - Two-master AXI4-Lite read-channel arbiter between the CPU fetch unit (IFU) and load/store unit (LSU).
// - Presents a single read master port to the crossbar's cpu_ar*/cpu_r* inputs.
// - LSU write channels (AW/W/B) bypass this block and connect straight to the crossbar.
// - One outstanding read at a time; round-robin fairness on simultaneous requests.
// PARAMETERS
// ADDR_W   32   read address width (matches INST_ADDR_BUS)
// DATA_W   64   read data width (matches MEM_DATA_BUS)
// RESP_W   2    rresp width (matches RRESP_DATA_BUS)
// PORTS
// clk             in   1       clock, all logic on rising edge
// rst             in   1       synchronous reset, active-low (0 = reset)
// ifu_araddr_i    in   ADDR_W  IFU read address
// ifu_arvalid_i   in   1       IFU address valid
// ifu_arready_o   out  1       IFU address accepted
// ifu_rdata_o     out  DATA_W  IFU read data
// ifu_rresp_o     out  RESP_W  IFU read response
// ifu_rvalid_o    out  1       IFU read data valid
// ifu_rready_i    in   1       IFU ready for data
// lsu_araddr_i    in   ADDR_W  LSU read address
// lsu_arvalid_i   in   1       LSU address valid
// lsu_arready_o   out  1       LSU address accepted
// lsu_rdata_o     out  DATA_W  LSU read data
// lsu_rresp_o     out  RESP_W  LSU read response
// lsu_rvalid_o    out  1       LSU read data valid
// lsu_rready_i    in   1       LSU ready for data
// xbar_araddr_o   out  ADDR_W  registered address to crossbar
// xbar_arvalid_o  out  1       registered address valid to crossbar
// xbar_arready_i  in   1       crossbar accepted address
// xbar_rdata_i    in   DATA_W  crossbar read data
// xbar_rresp_i    in   RESP_W  crossbar read response
// xbar_rvalid_i   in   1       crossbar read data valid
// xbar_rready_o   out  1       ready toward crossbar
// BEHAVIOUR
// - FSM states: IDLE, ADDR, DATA. Register grant (0 = IFU, 1 = LSU) and last_grant.
// - Reset: state IDLE, grant 0, last_grant 1 (IFU wins first tie), xbar_araddr_o 0, xbar_arvalid_o 0.
//   All *_arready_o, *_rvalid_o and xbar_rready_o are 0 in reset.
// - IDLE, arbitration:
//   - Only one arvalid high: that master wins.
//   - Both high: the master != last_grant wins.
//   - Winner's arready_o = 1 combinationally in that same cycle (handshake completes there).
//   - On that edge: latch winner's araddr into xbar_araddr_o, set xbar_arvalid_o = 1, grant = winner, go to ADDR.
//   - Loser's arready_o = 0. No arvalid high: stay in IDLE, all arready_o = 0.
// - ADDR:
//   - Hold xbar_arvalid_o = 1 and a stable xbar_araddr_o until xbar_arready_i = 1.
//   - On that edge: clear xbar_arvalid_o, go to DATA.
//   - Both *_arready_o = 0.
// - DATA:
//   - Granted master's rdata_o/rresp_o/rvalid_o = xbar_r* combinationally.
//   - xbar_rready_o = granted master's rready_i.
//   - Non-granted master's rvalid_o = 0; its rdata_o/rresp_o = 0.
//   - On xbar_rvalid_i && xbar_rready_o: last_grant = grant, go to IDLE.
//   - Backpressure (rready low): stay in DATA, no register changes.
// - Outside DATA: xbar_rready_o = 0 and both rvalid_o = 0. A stray xbar_rvalid_i is ignored.
// - Latency: master AR handshake in cycle N; xbar_arvalid_o high in N+1; earliest data to master in N+2.
//   Minimum one IDLE cycle between transactions.
// - rresp passes through unmodified; errors (SLVERR/DECERR) complete the transaction normally.
// - Request arriving while busy: held off (arready 0) until IDLE, then arbitrated normally.
// - arvalid withdrawn before grant: nothing captured.
// - Reset asserted mid-ADDR/DATA: transaction abandoned, state IDLE, xbar_arvalid_o 0 on next edge.
//   Crossbar and slaves are reset by the same rst.
// TESTING
// 1 Reset: hold rst=0 2 cycles with both arvalid=1 -> all outputs 0. First post-reset tie grants IFU.
// 2 IFU read 0x8000_0000, xbar_arready delayed 2 cycles, rdata 0x1234_5678_9ABC_DEF0 rresp 0:
//   xbar_araddr_o=0x8000_0000 held 3 cycles; IFU gets data; lsu_rvalid_o stays 0.
// 3 Both masters request continuously, 4 transactions -> grant order IFU, LSU, IFU, LSU;
//   addresses 0x8000_0000 / 0xa000_03f8 routed correctly.
// 4 DATA with ifu_rready=0 for 3 cycles, xbar_rvalid=1 -> xbar_rready_o=0, ifu_rdata_o stable,
//   completes on the cycle rready=1.
// 5 LSU arvalid raised while IFU in ADDR -> lsu_arready_o=0 until IFU DATA handshake;
//   LSU granted in the following IDLE cycle.
// 6 rst=0 during DATA -> next cycle state IDLE, xbar_arvalid_o=0, no rvalid_o forwarded;
//   fresh LSU read then completes with rresp 2'b10 passed through.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master AXI4-Lite read arbiter (IFU/LSU) with one outstanding read
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int RESP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr_i,
    input  logic              ifu_arvalid_i,
    output logic              ifu_arready_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic [RESP_W-1:0] ifu_rresp_o,
    output logic              ifu_rvalid_o,
    input  logic              ifu_rready_i,
    input  logic [ADDR_W-1:0] lsu_araddr_i,
    input  logic              lsu_arvalid_i,
    output logic              lsu_arready_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic [RESP_W-1:0] lsu_rresp_o,
    output logic              lsu_rvalid_o,
    input  logic              lsu_rready_i,
    output logic [ADDR_W-1:0] xbar_araddr_o,
    output logic              xbar_arvalid_o,
    input  logic              xbar_arready_i,
    input  logic [DATA_W-1:0] xbar_rdata_i,
    input  logic [RESP_W-1:0] xbar_rresp_i,
    input  logic              xbar_rvalid_i,
    output logic              xbar_rready_o
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t            state, state_nx;
    logic              grant, grant_nx;
    logic              last_grant, last_grant_nx;
    logic [ADDR_W-1:0] araddr_nx;
    logic              arvalid_nx;
    logic              winner;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            xbar_araddr_o  <= '0;
            xbar_arvalid_o <= 1'b0;
        end else begin
            state          <= state_nx;
            grant          <= grant_nx;
            last_grant     <= last_grant_nx;
            xbar_araddr_o  <= araddr_nx;
            xbar_arvalid_o <= arvalid_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        araddr_nx     = xbar_araddr_o;
        arvalid_nx    = xbar_arvalid_o;
        winner        = 1'b0;
        ifu_arready_o = 1'b0;
        lsu_arready_o = 1'b0;
        ifu_rdata_o   = '0;
        ifu_rresp_o   = '0;
        ifu_rvalid_o  = 1'b0;
        lsu_rdata_o   = '0;
        lsu_rresp_o   = '0;
        lsu_rvalid_o  = 1'b0;
        xbar_rready_o = 1'b0;

        // Handshake outputs are suppressed while reset is held, whatever the state.
        if (rst) begin
            case (state)
                IDLE: begin
                    winner = (ifu_arvalid_i && lsu_arvalid_i) ? ~last_grant : lsu_arvalid_i;
                    if (ifu_arvalid_i || lsu_arvalid_i) begin
                        ifu_arready_o = ~winner;
                        lsu_arready_o = winner;
                        araddr_nx     = winner ? lsu_araddr_i : ifu_araddr_i;
                        arvalid_nx    = 1'b1;
                        grant_nx      = winner;
                        state_nx      = ADDR;
                    end
                end
                ADDR: begin
                    if (xbar_arready_i) begin
                        arvalid_nx = 1'b0;
                        state_nx   = DATA;
                    end
                end
                DATA: begin
                    if (grant) begin
                        lsu_rdata_o   = xbar_rdata_i;
                        lsu_rresp_o   = xbar_rresp_i;
                        lsu_rvalid_o  = xbar_rvalid_i;
                        xbar_rready_o = lsu_rready_i;
                    end else begin
                        ifu_rdata_o   = xbar_rdata_i;
                        ifu_rresp_o   = xbar_rresp_i;
                        ifu_rvalid_o  = xbar_rvalid_i;
                        xbar_rready_o = ifu_rready_i;
                    end
                    if (xbar_rvalid_i && xbar_rready_o) begin
                        last_grant_nx = grant;
                        state_nx      = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr;
    logic        ifu_arvalid, lsu_arvalid;
    logic        ifu_arready_o, lsu_arready_o;
    logic [63:0] ifu_rdata_o, lsu_rdata_o;
    logic [1:0]  ifu_rresp_o, lsu_rresp_o;
    logic        ifu_rvalid_o, lsu_rvalid_o;
    logic        ifu_rready, lsu_rready;
    logic [31:0] xbar_araddr_o;
    logic        xbar_arvalid_o;
    logic        xbar_arready;
    logic [63:0] xbar_rdata;
    logic [1:0]  xbar_rresp;
    logic        xbar_rvalid;
    logic        xbar_rready_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .RESP_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_araddr_i   (ifu_araddr),
        .ifu_arvalid_i  (ifu_arvalid),
        .ifu_arready_o  (ifu_arready_o),
        .ifu_rdata_o    (ifu_rdata_o),
        .ifu_rresp_o    (ifu_rresp_o),
        .ifu_rvalid_o   (ifu_rvalid_o),
        .ifu_rready_i   (ifu_rready),
        .lsu_araddr_i   (lsu_araddr),
        .lsu_arvalid_i  (lsu_arvalid),
        .lsu_arready_o  (lsu_arready_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_rresp_o    (lsu_rresp_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_rready_i   (lsu_rready),
        .xbar_araddr_o  (xbar_araddr_o),
        .xbar_arvalid_o (xbar_arvalid_o),
        .xbar_arready_i (xbar_arready),
        .xbar_rdata_i   (xbar_rdata),
        .xbar_rresp_i   (xbar_rresp),
        .xbar_rvalid_i  (xbar_rvalid),
        .xbar_rready_o  (xbar_rready_o)
    );

    typedef struct {
        logic        ireq;
        logic        lreq;
        logic [31:0] ia;
        logic [31:0] la;
        logic [63:0] d;
        logic [1:0]  rr;
        int          dly;
        logic        exp_g;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE about 1ns after an edge; leaves in IDLE at the same phase.
    task automatic do_txn(input vec_t v);
        ifu_arvalid = v.ireq;
        lsu_arvalid = v.lreq;
        ifu_araddr  = v.ia;
        lsu_araddr  = v.la;
        #1;
        check("arready_winner", v.exp_g ? lsu_arready_o : ifu_arready_o, 1);
        check("arready_loser", v.exp_g ? ifu_arready_o : lsu_arready_o, 0);
        check("xbar_arvalid_idle", xbar_arvalid_o, 0);
        tick();
        for (int i = 0; i <= v.dly; i++) begin
            xbar_arready = (i == v.dly);
            #1;
            check("xbar_arvalid_addr", xbar_arvalid_o, 1);
            check("xbar_araddr", xbar_araddr_o, v.exp_a);
            check("arready_in_addr", ifu_arready_o | lsu_arready_o, 0);
            check("rvalid_in_addr", ifu_rvalid_o | lsu_rvalid_o, 0);
            tick();
        end
        xbar_arready = 1'b0;
        xbar_rvalid  = 1'b1;
        xbar_rdata   = v.d;
        xbar_rresp   = v.rr;
        ifu_rready   = 1'b1;
        lsu_rready   = 1'b1;
        #1;
        check("xbar_arvalid_data", xbar_arvalid_o, 0);
        check("rvalid_winner", v.exp_g ? lsu_rvalid_o : ifu_rvalid_o, 1);
        check("rvalid_loser", v.exp_g ? ifu_rvalid_o : lsu_rvalid_o, 0);
        check("rdata_winner", v.exp_g ? lsu_rdata_o : ifu_rdata_o, v.d);
        check("rresp_winner", v.exp_g ? lsu_rresp_o : ifu_rresp_o, v.rr);
        check("rdata_loser", v.exp_g ? ifu_rdata_o : lsu_rdata_o, 0);
        check("xbar_rready", xbar_rready_o, 1);
        tick();
        xbar_rvalid = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        ifu_arvalid  = 1'b1;
        lsu_arvalid  = 1'b1;
        ifu_araddr   = 32'h8000_0000;
        lsu_araddr   = 32'ha000_03f8;
        ifu_rready   = 1'b0;
        lsu_rready   = 1'b0;
        xbar_arready = 1'b0;
        xbar_rdata   = '0;
        xbar_rresp   = '0;
        xbar_rvalid  = 1'b0;

        vecs[0] = '{1, 1, 32'h8000_0000, 32'ha000_03f8, 64'h1111_0000_0000_0001, 2'b00, 0, 0, 32'h8000_0000};
        vecs[1] = '{1, 1, 32'h8000_0000, 32'ha000_03f8, 64'h2222_0000_0000_0002, 2'b00, 1, 1, 32'ha000_03f8};
        vecs[2] = '{1, 1, 32'h8000_0000, 32'ha000_03f8, 64'h3333_0000_0000_0003, 2'b00, 0, 0, 32'h8000_0000};
        vecs[3] = '{1, 1, 32'h8000_0000, 32'ha000_03f8, 64'h4444_0000_0000_0004, 2'b01, 0, 1, 32'ha000_03f8};
        vecs[4] = '{1, 0, 32'h8000_0000, 32'h0,         64'h1234_5678_9abc_def0, 2'b00, 2, 0, 32'h8000_0000};
        vecs[5] = '{0, 1, 32'h0,         32'h0000_1230, 64'hdead_beef_0bad_f00d, 2'b11, 1, 1, 32'h0000_1230};
        vecs[6] = '{1, 0, 32'h0000_0040, 32'h0,         64'h0000_0000_ffff_ffff, 2'b00, 0, 0, 32'h0000_0040};

        // Reset held with both masters requesting: everything stays quiet.
        tick();
        check("rst_arready", {ifu_arready_o, lsu_arready_o}, 0);
        check("rst_xbar", {xbar_arvalid_o, xbar_rready_o, ifu_rvalid_o, lsu_rvalid_o}, 0);
        tick();
        check("rst_xbar_araddr", xbar_araddr_o, 0);
        check("rst_arready2", {ifu_arready_o, lsu_arready_o}, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;

        // Backpressure in DATA, then a stray rvalid in IDLE.
        tick();
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0100;
        tick();
        ifu_arvalid  = 1'b0;
        xbar_arready = 1'b1;
        tick();
        xbar_arready = 1'b0;
        xbar_rvalid  = 1'b1;
        xbar_rdata   = 64'hcafe_f00d_0000_5555;
        ifu_rready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_xbar_rready", xbar_rready_o, 0);
            check("bp_ifu_rvalid", ifu_rvalid_o, 1);
            check("bp_ifu_rdata", ifu_rdata_o, 64'hcafe_f00d_0000_5555);
            tick();
        end
        ifu_rready = 1'b1;
        #1;
        check("bp_release_rready", xbar_rready_o, 1);
        tick();
        check("stray_rvalid_ifu", ifu_rvalid_o, 0);
        check("stray_xbar_rready", xbar_rready_o, 0);
        xbar_rvalid = 1'b0;

        // LSU request while IFU is busy.
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0200;
        tick();
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'ha000_0010;
        #1;
        check("busy_lsu_arready_addr", lsu_arready_o, 0);
        tick();
        check("busy_lsu_arready_addr2", lsu_arready_o, 0);
        xbar_arready = 1'b1;
        tick();
        xbar_arready = 1'b0;
        xbar_rvalid  = 1'b1;
        xbar_rdata   = 64'h77;
        #1;
        check("busy_lsu_arready_data", lsu_arready_o, 0);
        check("busy_ifu_rvalid", ifu_rvalid_o, 1);
        tick();
        xbar_rvalid = 1'b0;
        #1;
        check("busy_lsu_granted", lsu_arready_o, 1);
        tick();
        lsu_arvalid = 1'b0;
        check("busy_lsu_addr", xbar_araddr_o, 32'ha000_0010);
        xbar_arready = 1'b1;
        tick();
        xbar_arready = 1'b0;
        xbar_rvalid  = 1'b1;
        xbar_rresp   = 2'b00;
        #1;
        check("busy_lsu_rvalid", lsu_rvalid_o, 1);
        tick();
        xbar_rvalid = 1'b0;

        // Reset during DATA abandons the transaction.
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0300;
        tick();
        ifu_arvalid  = 1'b0;
        xbar_arready = 1'b1;
        tick();
        xbar_arready = 1'b0;
        xbar_rvalid  = 1'b1;
        rst          = 1'b0;
        #1;
        check("rst_data_ifu_rvalid", ifu_rvalid_o, 0);
        check("rst_data_xbar_rready", xbar_rready_o, 0);
        tick();
        rst = 1'b1;
        #1;
        check("rst_data_xbar_arvalid", xbar_arvalid_o, 0);
        check("rst_data_no_forward", ifu_rvalid_o | lsu_rvalid_o, 0);
        xbar_rvalid = 1'b0;
        do_txn('{0, 1, 32'h0, 32'ha000_0020, 64'h5a5a_5a5a_a5a5_a5a5, 2'b10, 0, 1, 32'ha000_0020});
        lsu_arvalid = 1'b0;

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
